// File: rtl/fp_norm_pack_pkg.sv
// fp_pkg: shared definitions for the floating-adder output stage.
//   - field widths and exponent bias of single precision
//   - canonical special-value encodings
//   - bit positions inside the raw mantissa {carry, hidden, frac, G, R, S}
//   - control state encoding of fp_norm_pack
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 5;
    localparam int BIAS   = 127;

    localparam logic [31:0] POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF  = 32'hFF80_0000;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_ZERO = 32'h0000_0000;

    // Raw mantissa bit positions (default widths). G/R/S sit at the
    // bottom regardless of width, so the RTL uses those directly.
    localparam int CARRY  = MANT_W - 1;
    localparam int HIDDEN = MANT_W - 2;
    localparam int G      = 2;
    localparam int R      = 1;
    localparam int S      = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fp_norm_pack_if.sv
// fp_norm_pack_if: handshake bundle between the add/sub datapath, the
// normalise/pack stage and the adder result register.
//   input side : in_valid/in_ready, in_normal, special_result,
//                in_sign, in_exp, in_mant
//   output side: out_valid/out_ready, result, flag_overflow,
//                flag_underflow, flag_inexact
//   master = producer/consumer around the block, slave = fp_norm_pack.
interface fp_norm_pack_if #(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int FRAC_W = fp_pkg::FRAC_W
);
    localparam int MANT_W = FRAC_W + 5;
    localparam int W      = 1 + EXP_W + FRAC_W;

    logic              in_valid;
    logic              in_ready;
    logic              in_normal;
    logic [W-1:0]      special_result;
    logic              in_sign;
    logic [EXP_W:0]    in_exp;
    logic [MANT_W-1:0] in_mant;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      result;
    logic              flag_overflow;
    logic              flag_underflow;
    logic              flag_inexact;

    modport master (
        output in_valid, in_normal, special_result, in_sign, in_exp, in_mant,
        output out_ready,
        input  in_ready, out_valid, result,
        input  flag_overflow, flag_underflow, flag_inexact
    );

    modport slave (
        input  in_valid, in_normal, special_result, in_sign, in_exp, in_mant,
        input  out_ready,
        output in_ready, out_valid, result,
        output flag_overflow, flag_underflow, flag_inexact
    );

endinterface

// File: rtl/fp_round_rne.sv
// fp_round_rne: combinational round-to-nearest-even and IEEE-754 pack.
//   sign, exp  : sign and biased exponent of a normalised (or minimum-
//                exponent subnormal) value
//   mant       : {hidden, frac, G, R, S} (carry already folded away)
//   result     : packed word; infinity on overflow
//   overflow / underflow / inexact : exception flags for this result
module fp_round_rne #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int MANT_W = FRAC_W + 5
) (
    input  logic                  sign,
    input  logic [EXP_W:0]        exp,
    input  logic [MANT_W-2:0]     mant,
    output logic [EXP_W+FRAC_W:0] result,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  inexact
);
    import fp_pkg::*;

    localparam int             HB      = MANT_W - 2;
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    logic                  hidden;
    logic [EXP_W:0]        exp_field;
    logic [FRAC_W-1:0]     frac;
    logic                  grs;
    logic                  inc;
    logic [EXP_W+FRAC_W:0] sum;
    logic [EXP_W:0]        exp_rnd;
    logic                  ovf;

    assign hidden    = mant[HB];
    // No hidden bit means the value is subnormal: encode a zero exponent.
    assign exp_field = hidden ? exp : '0;
    assign frac      = mant[HB-1:3];
    assign grs       = mant[G] | mant[R] | mant[S];
    assign inc       = mant[G] & (mant[R] | mant[S] | frac[0]);

    // Rounding over the joined {exp, frac} field: a fraction carry-out
    // bumps the exponent (and promotes a max subnormal to min normal).
    assign sum     = {exp_field, frac} + (EXP_W+FRAC_W+1)'(inc);
    assign exp_rnd = sum[EXP_W+FRAC_W:FRAC_W];
    assign ovf     = (exp_field >= EXP_MAX) || (exp_rnd >= EXP_MAX);

    assign result    = ovf ? {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}}
                           : {sign, sum[EXP_W+FRAC_W-1:0]};
    assign overflow  = ovf;
    assign inexact   = grs | ovf;
    assign underflow = (exp_field == '0) & grs;

endmodule

// File: rtl/fp_norm_pack.sv
// fp_norm_pack: output stage of the single-precision adder. Normalises the
// raw sum one bit per cycle, rounds to nearest-even and packs the result,
// or forwards a precomputed special-case word.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fp_norm_pack_if.slave (valid/ready in and out, raw sum
//                fields, special_result, packed result and flags)
// One operation in flight; no input is accepted until the result leaves.
module fp_norm_pack #(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int FRAC_W = fp_pkg::FRAC_W,
    parameter int MANT_W = FRAC_W + 5
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_norm_pack_if.slave bus
);
    import fp_pkg::*;

    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int CB = MANT_W - 1;
    localparam int HB = MANT_W - 2;

    state_t            state;
    logic              sign_r;
    logic [EXP_W:0]    exp_r;
    logic [MANT_W-1:0] mant_r;
    logic [W-1:0]      res_r;
    logic              ovf_r, unf_r, inx_r;

    logic [W-1:0]      rnd_res;
    logic              rnd_ovf, rnd_unf, rnd_inx;

    // Carry is always cleared before ROUND, so only {hidden..S} is passed.
    fp_round_rne #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W),
        .MANT_W (MANT_W)
    ) u_round (
        .sign      (sign_r),
        .exp       (exp_r),
        .mant      (mant_r[HB:0]),
        .result    (rnd_res),
        .overflow  (rnd_ovf),
        .underflow (rnd_unf),
        .inexact   (rnd_inx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sign_r <= 1'b0;
            exp_r  <= '0;
            mant_r <= '0;
            res_r  <= '0;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
            inx_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_r <= bus.in_sign;
                        exp_r  <= bus.in_exp;
                        mant_r <= bus.in_mant;
                        if (!bus.in_normal) begin
                            res_r <= bus.special_result;
                            ovf_r <= 1'b0;
                            unf_r <= 1'b0;
                            inx_r <= 1'b0;
                            state <= DONE;
                        end else begin
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (mant_r[CB]) begin
                        // Right shift folds the dropped R into sticky.
                        mant_r <= {1'b0, mant_r[CB:2], mant_r[R] | mant_r[S]};
                        exp_r  <= exp_r + (EXP_W+1)'(1);
                        state  <= ROUND;
                    end else if (mant_r[HB] || exp_r == (EXP_W+1)'(1)) begin
                        // exp==1 with no hidden bit rounds as a subnormal.
                        state <= ROUND;
                    end else if (mant_r == '0) begin
                        // Exact cancellation always yields +0.
                        res_r <= '0;
                        ovf_r <= 1'b0;
                        unf_r <= 1'b0;
                        inx_r <= 1'b0;
                        state <= DONE;
                    end else begin
                        mant_r <= {mant_r[CB-1:0], 1'b0};
                        exp_r  <= exp_r - (EXP_W+1)'(1);
                    end
                end
                ROUND: begin
                    res_r <= rnd_res;
                    ovf_r <= rnd_ovf;
                    unf_r <= rnd_unf;
                    inx_r <= rnd_inx;
                    state <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready       = (state == IDLE);
    assign bus.out_valid      = (state == DONE);
    assign bus.result         = res_r;
    assign bus.flag_overflow  = ovf_r;
    assign bus.flag_underflow = unf_r;
    assign bus.flag_inexact   = inx_r;

endmodule

// File: tb/tb_fp_norm_pack.sv
// Self-checking bench for fp_norm_pack: directed corner cases, special
// pass-through, randomized operations against a value-level model,
// backpressure hold and asynchronous reset mid-operation.
module tb_fp_norm_pack;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fp_norm_pack_if bus ();

    fp_norm_pack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        s;
        logic [8:0]  e;
        logic [27:0] m;
        logic [31:0] r;
        logic [2:0]  f;
        int          lat;
    } vec_t;

    // Reference: normalise the integer mantissa, then round the value that
    // sits above the three guard bits to nearest, ties to an even LSB.
    // Flags packed as {overflow, underflow, inexact}.
    function automatic void model(input logic s, input int e_in, input logic [27:0] m_in,
                                  output logic [31:0] r, output logic [2:0] f, output int lat);
        longint m, q, rem, word, fld;
        int e;
        bit hid, up, ovf;
        m = longint'(m_in);
        e = e_in;
        lat = 3;
        if (m >= (64'd1 << 27)) begin
            m = (m >> 1) | (m & 1);
            e = e + 1;
        end else if (m == 0 && e != 1) begin
            r = 32'h0; f = 3'b000; lat = 2;
            return;
        end else begin
            while (m < (64'd1 << 26) && e > 1) begin
                m = m << 1; e = e - 1; lat = lat + 1;
            end
        end
        hid  = (m >= (64'd1 << 26));
        q    = m >> 3;
        rem  = m % 8;
        up   = (rem > 4) || (rem == 4 && (q % 2) == 1);
        fld  = hid ? longint'(e) : 0;
        word = fld * (64'd1 << 23) + (q % (64'd1 << 23)) + longint'(up);
        ovf  = (fld >= 255) || (word >= 255 * (64'd1 << 23));
        if (ovf) begin
            r = {s, 8'hFF, 23'h0};
            f = 3'b101;
        end else begin
            r = {s, word[30:0]};
            f = {1'b0, (!hid && rem != 0), (rem != 0)};
        end
    endfunction

    // Issue one operation from IDLE (called #1 after a rising edge) and wait
    // for its result; lat counts edges from the accept edge (=1).
    task automatic run_op(input logic s, input logic [8:0] e, input logic [27:0] m,
                          input logic nrm, input logic [31:0] sp,
                          output logic [31:0] r, output logic [2:0] f, output int lat);
        bus.in_sign = s;
        bus.in_exp = e;
        bus.in_mant = m;
        bus.in_normal = nrm;
        bus.special_result = sp;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        r = bus.result;
        f = {bus.flag_overflow, bus.flag_underflow, bus.flag_inexact};
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b required 1/0",
                     bus.in_ready, bus.out_valid);
        end
        n_tests++;
        if (bus.result !== 32'h0 ||
            {bus.flag_overflow, bus.flag_underflow, bus.flag_inexact} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_result: result=%h flags=%b required 0/000", bus.result,
                     {bus.flag_overflow, bus.flag_underflow, bus.flag_inexact});
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        vec_t v [8];
        logic [31:0] r;
        logic [2:0]  f;
        int          lat;
        v[0] = '{1'b0, 9'd127, 28'h8000000, 32'h40000000, 3'b000, 3};
        v[1] = '{1'b0, 9'd127, 28'h0000000, 32'h00000000, 3'b000, 2};
        v[2] = '{1'b0, 9'd127, 28'h1000000, 32'h3E800000, 3'b000, 5};
        v[3] = '{1'b0, 9'd127, 28'h7FFFFFC, 32'h40000000, 3'b001, 3};
        v[4] = '{1'b0, 9'd127, 28'h7FFFFF4, 32'h3FFFFFFE, 3'b001, 3};
        v[5] = '{1'b0, 9'd254, 28'h8000000, 32'h7F800000, 3'b101, 3};
        v[6] = '{1'b0, 9'd1,   28'h0800001, 32'h00100000, 3'b011, 3};
        v[7] = '{1'b1, 9'd130, 28'h4000008, 32'hC1000001, 3'b000, 3};
        for (int i = 0; i < 8; i++) begin
            run_op(v[i].s, v[i].e, v[i].m, 1'b1, 32'hDEADBEEF, r, f, lat);
            n_tests++;
            if (r !== v[i].r || f !== v[i].f || lat !== v[i].lat) begin
                n_fail++;
                $display("FAIL directed_%0d: result=%h flags=%b lat=%0d required %h/%b/%0d",
                         i, r, f, lat, v[i].r, v[i].f, v[i].lat);
            end
        end
    endtask

    task automatic test_special();
        logic [31:0] r, sp;
        logic [2:0]  f;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            sp = (i == 0) ? 32'h7FC00000 : $urandom;
            run_op(1'($urandom), 9'($urandom_range(1, 254)), 28'($urandom), 1'b0, sp, r, f, lat);
            n_tests++;
            if (r !== sp || f !== 3'b000 || lat !== 1) begin
                n_fail++;
                $display("FAIL special_%0d: result=%h flags=%b lat=%0d required %h/000/1",
                         i, r, f, lat, sp);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] r, er;
        logic [2:0]  f, ef;
        int          lat, elat, e;
        logic [27:0] m;
        logic        s;
        for (int i = 0; i < 300; i++) begin
            s = 1'($urandom);
            case ($urandom_range(0, 7))
                0: e = 1;
                1: e = 254;
                2: e = $urandom_range(1, 8);
                default: e = $urandom_range(1, 254);
            endcase
            m = 28'($urandom) >> $urandom_range(0, 27);
            if ($urandom_range(0, 15) == 0) m = 28'h0;
            model(s, e, m, er, ef, elat);
            run_op(s, 9'(e), m, 1'b1, 32'h0, r, f, lat);
            n_tests++;
            if (r !== er || f !== ef || lat !== elat) begin
                n_fail++;
                $display("FAIL random_%0d s=%b e=%0d m=%h: result=%h flags=%b lat=%0d required %h/%b/%0d",
                         i, s, e, m, r, f, lat, er, ef, elat);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bus.out_ready = 1'b0;
        bus.in_sign = 1'b0;
        bus.in_exp = 9'd127;
        bus.in_mant = 28'h8000000;
        bus.in_normal = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        n_tests++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL bp_latency: lat=%0d required 3", lat);
        end
        for (int c = 0; c < 5; c++) begin
            // Offer a different operand while stalled; it must not be taken.
            bus.in_valid = 1'b1;
            bus.in_mant = 28'h1000000;
            @(posedge clk); #1;
            n_tests++;
            if (bus.result !== 32'h40000000 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: result=%h out_valid=%b in_ready=%b required 40000000/1/0",
                         c, bus.result, bus.out_valid, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic [2:0]  f;
        int          lat;
        // Long left-normalisation keeps the block in NORM for many cycles.
        bus.in_sign = 1'b0;
        bus.in_exp = 9'd127;
        bus.in_mant = 28'h0000001;
        bus.in_normal = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: out_valid=%b in_ready=%b result=%h required 0/1/0",
                     bus.out_valid, bus.in_ready, bus.result);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(1'b0, 9'd127, 28'h8000000, 1'b1, 32'h0, r, f, lat);
        n_tests++;
        if (r !== 32'h40000000 || f !== 3'b000 || lat !== 3) begin
            n_fail++;
            $display("FAIL reset_recover: result=%h flags=%b lat=%0d required 40000000/000/3",
                     r, f, lat);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_normal = 1'b1;
        bus.special_result = 32'h0;
        bus.in_sign = 1'b0;
        bus.in_exp = 9'd1;
        bus.in_mant = 28'h0;
        bus.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_special();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
